mem_access_unit: RTL and testbench

Load/store access stage between the EX/MEM pipeline register and the word-addressed data memory. It accepts one memory request at a time over a valid/ready handshake and performs byte, halfword and word accesses against the full-word memory port. Sub-word stores use a read-modify-write sequence. Load data is extended and returned to the MEM/WB stage through a registered response with backpressure.

---
 rtl/mem_access_unit_pkg.sv | 52 +++++
 rtl/mem_access_unit_if.sv | 44 ++++
 rtl/mem_access_unit_load_extend.sv | 34 +++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared op encodings, FSM state type and lane helpers for the load/store stage.
package mem_access_unit_pkg;

    localparam logic [2:0] MEM_OP_LB  = 3'b000;
    localparam logic [2:0] MEM_OP_LH  = 3'b001;
    localparam logic [2:0] MEM_OP_LW  = 3'b010;
    localparam logic [2:0] MEM_OP_SW  = 3'b011;
    localparam logic [2:0] MEM_OP_LBU = 3'b100;
    localparam logic [2:0] MEM_OP_LHU = 3'b101;
    localparam logic [2:0] MEM_OP_SB  = 3'b110;
    localparam logic [2:0] MEM_OP_SH  = 3'b111;

    localparam logic [31:0] INIT_32 = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == MEM_OP_SW) || (op == MEM_OP_SB) || (op == MEM_OP_SH);
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return lo[0];
            MEM_OP_LW, MEM_OP_SW:             return lo != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

    // SH ignores lo[0]: the halfword lane is chosen by lo[1] alone.
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] lo, input logic [2:0] op);
        logic [31:0] m;
        m = word;
        if (op == MEM_OP_SB) begin
            case (lo)
                2'd0:    m[7:0]   = wdata[7:0];
                2'd1:    m[15:8]  = wdata[7:0];
                2'd2:    m[23:16] = wdata[7:0];
                default: m[31:24] = wdata[7:0];
            endcase
        end else if (lo[1]) begin
            m[31:16] = wdata;
        end else begin
            m[15:0] = wdata;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide data memory port of the load/store stage.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [4:0]        req_rd;

    logic              DataMemWe;
    logic [ADDR_W-1:0] DataMemAddr;
    logic [DATA_W-1:0] DataMemIn;
    logic [DATA_W-1:0] DataMemOut;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [4:0]        resp_rd;
    logic              resp_wb;
`ifdef MEM_ALIGN_CHECK_EN
    logic              resp_exc;
`endif

    // master: pipeline + memory side; slave: the access unit itself
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready, DataMemOut,
        input  req_ready, DataMemWe, DataMemAddr, DataMemIn, resp_valid, resp_data, resp_rd, resp_wb
`ifdef MEM_ALIGN_CHECK_EN
        , input resp_exc
`endif
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready, DataMemOut,
        output req_ready, DataMemWe, DataMemAddr, DataMemIn, resp_valid, resp_data, resp_rd, resp_wb
`ifdef MEM_ALIGN_CHECK_EN
        , output resp_exc
`endif
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword lane of a memory word and sign/zero-extends it.
// Purely combinational; no backpressure.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        result   = word;
        case (op)
            MEM_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: result = {24'h0, byte_sel};
            MEM_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LHU: result = {16'h0, half_sel};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage to word-addressed memory; SB/SH via read-modify-write; MEM_ALIGN_CHECK_EN adds misalign traps.
// Latency: 1 cycle accept->resp_valid for loads/SW/traps, 2 cycles for SB/SH.
// Backpressure: req_ready drops while in RMW or while a held response is not being drained.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_unit_if.slave    bus
);

    state_t            state;
    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_op;
    logic [15:0]       cap_wdata;
    logic [DATA_W-1:0] cap_word;
    logic [4:0]        cap_rd;

    logic              accept;
    logic              is_st;
    logic              is_sub_st;
    logic              misal;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] rmw_word;

    load_extend u_load_extend (
        .word    (bus.DataMemOut),
        .addr_lo (bus.req_addr[1:0]),
        .op      (bus.req_op),
        .result  (ld_data)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign misal = op_misaligned(bus.req_op, bus.req_addr[1:0]);
`else
    assign misal = 1'b0;
`endif

    // rst_n gating keeps a reset cycle from accepting or writing anything.
    assign bus.req_ready = rst_n && (state == ST_IDLE) && (!bus.resp_valid || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_st         = op_is_store(bus.req_op);
    assign is_sub_st     = ((bus.req_op == MEM_OP_SB) || (bus.req_op == MEM_OP_SH)) && !misal;
    assign rmw_word      = merge_lane(cap_word, cap_wdata, cap_addr[1:0], cap_op);

    always_comb begin
        bus.DataMemWe   = 1'b0;
        bus.DataMemAddr = {bus.req_addr[ADDR_W-1:2], 2'b00};
        bus.DataMemIn   = bus.req_wdata;
        if (state == ST_RMW) begin
            bus.DataMemWe   = rst_n;
            bus.DataMemAddr = {cap_addr[ADDR_W-1:2], 2'b00};
            bus.DataMemIn   = rmw_word;
        end else if (accept && (bus.req_op == MEM_OP_SW) && !misal) begin
            bus.DataMemWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= INIT_32;
            bus.resp_rd    <= '0;
            bus.resp_wb    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            bus.resp_exc   <= 1'b0;
`endif
            cap_addr       <= '0;
            cap_op         <= MEM_OP_LB;
            cap_wdata      <= '0;
            cap_word       <= '0;
            cap_rd         <= '0;
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                bus.resp_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && is_sub_st) begin
                        state     <= ST_RMW;
                        cap_addr  <= bus.req_addr;
                        cap_op    <= bus.req_op;
                        cap_wdata <= bus.req_wdata[15:0];
                        cap_word  <= bus.DataMemOut;
                        cap_rd    <= bus.req_rd;
                    end else if (accept) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_rd    <= bus.req_rd;
                        bus.resp_wb    <= !is_st && !misal;
                        bus.resp_data  <= (is_st || misal) ? '0 : ld_data;
`ifdef MEM_ALIGN_CHECK_EN
                        bus.resp_exc   <= misal;
`endif
                    end
                end
                ST_RMW: begin
                    state          <= ST_IDLE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rd    <= cap_rd;
                    bus.resp_wb    <= 1'b0;
                    bus.resp_data  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                    bus.resp_exc   <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, then random traffic vs. a reference model.
module tb_mem_access_unit;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SW = 3'b011;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SB = 3'b110, SH = 3'b111;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: write sampled mid-cycle, committed on the rising edge.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int          we_cnt = 0;
    logic        wr_pend = 1'b0;
    logic [5:0]  wr_idx;
    logic [31:0] wr_dat;

    assign bus.DataMemOut = mem[bus.DataMemAddr[7:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_pend = bus.DataMemWe;
        wr_idx  = bus.DataMemAddr[7:2];
        wr_dat  = bus.DataMemIn;
        if (bus.DataMemWe) check("wr_addr_aligned", {30'd0, bus.DataMemAddr[1:0]}, 32'd0);
    end

    always @(posedge clk) begin
        if (wr_pend) begin
            mem[wr_idx] = wr_dat;
            we_cnt++;
            wr_pend = 1'b0;
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [7:0] a, input logic [2:0] op);
        logic [31:0] v;
        int sb = 8 * int'(a[1:0]);
        int sh = 16 * int'(a[1]);
        case (op)
            LB:      begin v = (w >> sb) & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            LBU:     v = (w >> sb) & 32'hFF;
            LH:      begin v = (w >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            LHU:     v = (w >> sh) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [7:0] a, input logic [2:0] op);
        logic [31:0] mask;
        int s;
        if (op == SW) return d;
        if (op == SB) begin s = 8 * int'(a[1:0]); mask = 32'hFF << s; end
        else          begin s = 16 * int'(a[1]);  mask = 32'hFFFF << s; end
        return (w & ~mask) | ((d << s) & mask);
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] op, input logic [7:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        if (op == LW || op == SW)              return (a % 4) != 0;
        return 1'b0;
`else
        return (op == 3'b000) && (a == 8'hFF) && 1'b0;
`endif
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
        bit done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = {24'h0, addr};
        bus.req_wdata = wdata;
        bus.req_rd    = rd;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = bus.req_ready;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_wb;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wb;
        logic        exc;
    } exp_t;

    localparam int NV = 10;
    vec_t vt [NV];
    exp_t exp_q [$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   w0;
        int   exp_writes;
        bit   acc;
        exp_t e;
        logic [7:0] a;

        vt[0] = '{LB,  8'h12, 32'h0,         32'hFFFF_FFFF, 1'b1};
        vt[1] = '{LBU, 8'h13, 32'h0,         32'h0000_0080, 1'b1};
        vt[2] = '{LH,  8'h10, 32'h0,         32'h0000_7F01, 1'b1};
        vt[3] = '{LHU, 8'h12, 32'h0,         32'h0000_80FF, 1'b1};
        vt[4] = '{LH,  8'h12, 32'h0,         32'hFFFF_80FF, 1'b1};
        vt[5] = '{LB,  8'h10, 32'h0,         32'h0000_0001, 1'b1};
        vt[6] = '{LBU, 8'h11, 32'h0,         32'h0000_007F, 1'b1};
        vt[7] = '{LW,  8'h10, 32'h0,         32'h80FF_7F01, 1'b1};
        vt[8] = '{SW,  8'h14, 32'hA5A5_0F0F, 32'h0000_0000, 1'b0};
        vt[9] = '{LW,  8'h14, 32'h0,         32'hA5A5_0F0F, 1'b1};

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[4] = 32'h80FF_7F01;

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = LB; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_rd = '0; bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_rd", {27'd0, bus.resp_rd}, 32'd0);
        check("rst_resp_wb", {31'd0, bus.resp_wb}, 32'd0);
        check("rst_we", {31'd0, bus.DataMemWe}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;

        // Vector table: single-cycle accesses, response one cycle after accept
        for (int i = 0; i < NV; i++) begin
            issue(vt[i].op, vt[i].addr, vt[i].wdata, 5'(i + 1));
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'd0, bus.resp_valid}, 32'd1);
            check($sformatf("vec%0d_data", i), bus.resp_data, vt[i].exp_data);
            check($sformatf("vec%0d_wb", i), {31'd0, bus.resp_wb}, {31'd0, vt[i].exp_wb});
            check($sformatf("vec%0d_rd", i), {27'd0, bus.resp_rd}, i + 1);
            @(posedge clk); #1;
        end

        // SB read-modify-write
        mem[8] = 32'h1122_3344;
        w0 = we_cnt;
        bus.req_valid = 1'b1; bus.req_op = SB; bus.req_addr = 32'h21;
        bus.req_wdata = 32'hFFFF_FFAB; bus.req_rd = 5'd3;
        @(negedge clk);
        check("sb_c1_ready", {31'd0, bus.req_ready}, 32'd1);
        check("sb_c1_we", {31'd0, bus.DataMemWe}, 32'd0);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("sb_c2_we", {31'd0, bus.DataMemWe}, 32'd1);
        check("sb_c2_din", bus.DataMemIn, 32'h1122_AB44);
        check("sb_c2_addr", bus.DataMemAddr, 32'h20);
        check("sb_c2_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sb_c3_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("sb_c3_wb", {31'd0, bus.resp_wb}, 32'd0);
        check("sb_c3_rd", {27'd0, bus.resp_rd}, 32'd3);
        check("sb_c3_we", {31'd0, bus.DataMemWe}, 32'd0);
        check("sb_we_pulses", we_cnt - w0, 32'd1);
        check("sb_mem", mem[8], 32'h1122_AB44);
        @(posedge clk); #1;

        // Back-to-back SW then LW of the same word
        issue(SW, 8'h30, 32'hDEAD_BEEF, 5'd1);
        bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = 32'h30; bus.req_rd = 5'd2;
        @(negedge clk);
        check("b2b_lw_ready", {31'd0, bus.req_ready}, 32'd1);
        check("b2b_sw_wb", {31'd0, bus.resp_wb}, 32'd0);
        check("b2b_sw_rd", {27'd0, bus.resp_rd}, 32'd1);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_lw_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("b2b_lw_data", bus.resp_data, 32'hDEAD_BEEF);
        check("b2b_lw_rd", {27'd0, bus.resp_rd}, 32'd2);
        @(posedge clk); #1;

        // Backpressure: held LW response, queued SW must wait for the drain
        bus.resp_ready = 1'b0;
        issue(LW, 8'h10, 32'h0, 5'd5);
        bus.req_valid = 1'b1; bus.req_op = SW; bus.req_addr = 32'h34;
        bus.req_wdata = 32'h0BAD_F00D; bus.req_rd = 5'd6;
        w0 = we_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("bp_resp_data", bus.resp_data, 32'h80FF_7F01);
            check("bp_resp_rd", {27'd0, bus.resp_rd}, 32'd5);
            check("bp_we", {31'd0, bus.DataMemWe}, 32'd0);
            @(posedge clk); #1;
        end
        check("bp_no_write", we_cnt - w0, 32'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_ready", {31'd0, bus.req_ready}, 32'd1);
        check("bp_drain_we", {31'd0, bus.DataMemWe}, 32'd1);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp_sw_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("bp_sw_rd", {27'd0, bus.resp_rd}, 32'd6);
        check("bp_sw_writes", we_cnt - w0, 32'd1);
        check("bp_sw_mem", mem[13], 32'h0BAD_F00D);
        @(posedge clk); #1;

        // Reset asserted during the RMW cycle of an SH
        mem[9] = 32'hCAFE_F00D;
        w0 = we_cnt;
        issue(SH, 8'h26, 32'h0000_BEEF, 5'd7);
        bus.req_addr = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstrmw_we", {31'd0, bus.DataMemWe}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstrmw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rstrmw_resp_data", bus.resp_data, 32'd0);
        check("rstrmw_resp_rd", {27'd0, bus.resp_rd}, 32'd0);
        check("rstrmw_resp_wb", {31'd0, bus.resp_wb}, 32'd0);
        check("rstrmw_we2", {31'd0, bus.DataMemWe}, 32'd0);
        check("rstrmw_addr", bus.DataMemAddr, 32'd0);
        check("rstrmw_mem", mem[9], 32'hCAFE_F00D);
        check("rstrmw_writes", we_cnt - w0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rstrmw_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;

        // Misaligned SW / LH
        mem[16] = 32'h5555_5555;
        w0 = we_cnt;
        issue(SW, 8'h42, 32'h1234_5678, 5'd8);
        @(negedge clk);
        check("mis_sw_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("mis_sw_wb", {31'd0, bus.resp_wb}, 32'd0);
        check("mis_sw_data", bus.resp_data, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_sw_exc", {31'd0, bus.resp_exc}, 32'd1);
        check("mis_sw_writes", we_cnt - w0, 32'd0);
        check("mis_sw_mem", mem[16], 32'h5555_5555);
`else
        check("mis_sw_writes", we_cnt - w0, 32'd1);
        check("mis_sw_mem", mem[16], 32'h1234_5678);
`endif
        @(posedge clk); #1;
        issue(LH, 8'h11, 32'h0, 5'd9);
        @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_lh_exc", {31'd0, bus.resp_exc}, 32'd1);
        check("mis_lh_data", bus.resp_data, 32'd0);
        check("mis_lh_wb", {31'd0, bus.resp_wb}, 32'd0);
`else
        check("mis_lh_data", bus.resp_data, 32'h0000_7F01);
        check("mis_lh_wb", {31'd0, bus.resp_wb}, 32'd1);
`endif
        @(posedge clk); #1;

        // Random traffic against the reference model
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        w0 = we_cnt;
        exp_writes = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_data", bus.resp_data, e.data);
                    check("rnd_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
                    check("rnd_wb", {31'd0, bus.resp_wb}, {31'd0, e.wb});
`ifdef MEM_ALIGN_CHECK_EN
                    check("rnd_exc", {31'd0, bus.resp_exc}, {31'd0, e.exc});
`endif
                end
            end
            acc = bus.req_valid && bus.req_ready;
            if (acc) begin
                a      = bus.req_addr[7:0];
                e.rd   = bus.req_rd;
                e.exc  = ref_misaligned(bus.req_op, a);
                e.data = 32'd0;
                e.wb   = 1'b0;
                if (!e.exc) begin
                    if (bus.req_op == SW || bus.req_op == SB || bus.req_op == SH) begin
                        ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], bus.req_wdata, a, bus.req_op);
                        exp_writes++;
                    end else begin
                        e.data = ref_load(ref_mem[a[7:2]], a, bus.req_op);
                        e.wb   = 1'b1;
                    end
                end
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            if (acc || !bus.req_valid) begin
                if (c < 2900 && $urandom_range(0, 2) != 0) begin
                    bus.req_valid = 1'b1;
                    bus.req_op    = 3'($urandom_range(0, 7));
                    bus.req_addr  = 32'($urandom_range(0, 63));
                    bus.req_wdata = $urandom;
                    bus.req_rd    = 5'($urandom_range(0, 31));
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        check("rnd_queue_drained", exp_q.size(), 32'd0);
        check("rnd_write_count", we_cnt - w0, exp_writes);
        for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
